wdog_phase_ctrl: RTL and testbench

WDOG_PHASE_CTRL -- requirements
Module: wdog_phase_ctrl

---
 rtl/wdog_phase_ctrl.sv | 158 +++++++++++++++
 tb/tb_wdog_phase_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wdog_phase_ctrl.sv
// Purpose: host watchdog with tick prescaler, elapsed counter, phase decode and a sticky timeout.
// Latency: timeout/evt/elapsed update on the tick edge; phase status lags state/elapsed by one sysclk.
// Backpressure: none; every strobe is honoured the cycle it arrives (priority we > clear > refresh > tick).
//
// Ports:
//   sysclk, reset (async active-low)
//   wdog_period_in/_we  : program period in ticks (0 disables)
//   wdog_refresh        : host kick, effective only while running
//   wdog_clear          : acknowledge a timeout and restart
//   wdog_period_status  : 0 disable, 1..4 quarter phase, 5 timeout
//   wdog_timeout        : sticky timeout level; wdog_timeout_evt pulses on its rising edge
//   wdog_elapsed        : current elapsed tick count
module wdog_phase_ctrl #(
  parameter int unsigned TICK_DIV = 49152
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic [15:0] wdog_period_in,
  input  logic        wdog_period_we,
  input  logic        wdog_refresh,
  input  logic        wdog_clear,
  output logic [2:0]  wdog_period_status,
  output logic        wdog_timeout,
  output logic        wdog_timeout_evt,
  output logic [15:0] wdog_elapsed
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_EXPIRED = 2'd2
  } state_t;

  localparam logic [2:0] WDOG_DISABLE     = 3'd0;
  localparam logic [2:0] WDOG_PHASE_ONE   = 3'd1;
  localparam logic [2:0] WDOG_PHASE_TWO   = 3'd2;
  localparam logic [2:0] WDOG_PHASE_THREE = 3'd3;
  localparam logic [2:0] WDOG_PHASE_FOUR  = 3'd4;
  localparam logic [2:0] WDOG_TIMEOUT     = 3'd5;

  // TICK_DIV may be 65536, so the terminal count still fits in 16 bits.
  localparam logic [15:0] PRESC_LAST = 16'(TICK_DIV - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_period;
  logic [15:0] r_presc;
  logic [15:0] r_elapsed;
  logic [2:0]  r_status;
  logic        r_timeout;
  logic        r_evt;

  logic        w_tick;
  logic        w_clear_hit;
  logic        w_refresh_hit;
  logic        w_expire;
  logic [16:0] w_elapsed_inc;
  logic [17:0] w_e4;
  logic [17:0] w_p1;
  logic [17:0] w_p2;
  logic [17:0] w_p3;
  logic [2:0]  w_status_nxt;

  assign w_tick        = (r_state == S_RUN) && (r_presc == PRESC_LAST);
  assign w_clear_hit   = wdog_clear && (r_state == S_EXPIRED);
  assign w_refresh_hit = wdog_refresh && (r_state == S_RUN);
  // 17-bit increment so the expiry compare cannot wrap at period 65535.
  assign w_elapsed_inc = {1'b0, r_elapsed} + 17'd1;
  assign w_expire      = w_tick && (w_elapsed_inc >= {1'b0, r_period});

  // Phase thresholds at full 18-bit width: 4*elapsed vs P, 2P, 3P.
  assign w_e4 = {r_elapsed, 2'b00};
  assign w_p1 = {2'b00, r_period};
  assign w_p2 = {1'b0, r_period, 1'b0};
  assign w_p3 = w_p1 + w_p2;

  // State register
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (wdog_period_we)     w_state_nxt = (wdog_period_in == 16'd0) ? S_IDLE : S_RUN;
    else if (w_clear_hit)   w_state_nxt = S_RUN;
    else if (w_refresh_hit) w_state_nxt = S_RUN;
    else if (w_expire)      w_state_nxt = S_EXPIRED;
  end

  // Output decode, registered below to give one cycle of status latency
  always_comb begin
    w_status_nxt = WDOG_DISABLE;
    case (r_state)
      S_IDLE:    w_status_nxt = WDOG_DISABLE;
      S_EXPIRED: w_status_nxt = WDOG_TIMEOUT;
      S_RUN: begin
        if (w_e4 < w_p1)      w_status_nxt = WDOG_PHASE_ONE;
        else if (w_e4 < w_p2) w_status_nxt = WDOG_PHASE_TWO;
        else if (w_e4 < w_p3) w_status_nxt = WDOG_PHASE_THREE;
        else                  w_status_nxt = WDOG_PHASE_FOUR;
      end
      default:   w_status_nxt = WDOG_DISABLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) r_status <= WDOG_DISABLE;
    else        r_status <= w_status_nxt;
  end

  // Datapath: period, prescaler, elapsed, timeout flags
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      r_period  <= 16'd0;
      r_presc   <= 16'd0;
      r_elapsed <= 16'd0;
      r_timeout <= 1'b0;
      r_evt     <= 1'b0;
    end else begin
      r_evt <= 1'b0;
      if (wdog_period_we) begin
        r_period  <= wdog_period_in;
        r_presc   <= 16'd0;
        r_elapsed <= 16'd0;
        r_timeout <= 1'b0;
      end else if (w_clear_hit) begin
        r_presc   <= 16'd0;
        r_elapsed <= 16'd0;
        r_timeout <= 1'b0;
      end else if (w_refresh_hit) begin
        r_presc   <= 16'd0;
        r_elapsed <= 16'd0;
      end else if (w_tick) begin
        r_presc <= 16'd0;
        if (w_expire) begin
          // Saturate at period so elapsed never exceeds it.
          r_elapsed <= r_period;
          r_timeout <= 1'b1;
          r_evt     <= 1'b1;
        end else begin
          r_elapsed <= w_elapsed_inc[15:0];
        end
      end else if (r_state == S_RUN) begin
        r_presc <= r_presc + 16'd1;
      end else begin
        r_presc <= 16'd0;
      end
    end
  end

  assign wdog_period_status = r_status;
  assign wdog_timeout       = r_timeout;
  assign wdog_timeout_evt   = r_evt;
  assign wdog_elapsed       = r_elapsed;

endmodule

// File: tb/tb_wdog_phase_ctrl.sv
// Scoreboard bench for wdog_phase_ctrl with TICK_DIV=4.
// Stimulus pushes expected (cycle, status, timeout, elapsed) records and expected evt cycles;
// a negedge monitor pops and compares them independently of the stimulus.
module tb_wdog_phase_ctrl;

  logic        sysclk;
  logic        reset;
  logic [15:0] wdog_period_in;
  logic        wdog_period_we;
  logic        wdog_refresh;
  logic        wdog_clear;
  logic [2:0]  wdog_period_status;
  logic        wdog_timeout;
  logic        wdog_timeout_evt;
  logic [15:0] wdog_elapsed;

  wdog_phase_ctrl #(.TICK_DIV(4)) dut (
    .sysclk             (sysclk),
    .reset              (reset),
    .wdog_period_in     (wdog_period_in),
    .wdog_period_we     (wdog_period_we),
    .wdog_refresh       (wdog_refresh),
    .wdog_clear         (wdog_clear),
    .wdog_period_status (wdog_period_status),
    .wdog_timeout       (wdog_timeout),
    .wdog_timeout_evt   (wdog_timeout_evt),
    .wdog_elapsed       (wdog_elapsed)
  );

  initial begin
    sysclk = 1'b0;
    forever #5 sysclk = ~sysclk;
  end

  // Number of rising edges seen so far; the monitor samples at the following negedge.
  int cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [2:0]  st;
    logic        to;
    logic [15:0] el;
    string       name;
  } exp_t;

  exp_t q[$];
  int   evt_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   done  = 1'b0;

  // Hand-computed phase for period 8, indexed by elapsed 0..7.
  localparam logic [2:0] PH8 [0:7] = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 4'd4};

  function automatic void push(int c, logic [2:0] st, logic to, logic [15:0] el, string nm);
    exp_t e;
    e.cyc = c; e.st = st; e.to = to; e.el = el; e.name = nm;
    q.push_back(e);
  endfunction

  // Period-8 count from a fresh start at cycle b: elapsed = t/4, status lags by one cycle.
  function automatic void push_ramp(int b, int len, logic [2:0] s0, string nm);
    for (int t = 0; t < len; t++)
      push(b + t, (t == 0) ? s0 : PH8[(t - 1) / 4], 1'b0, 16'(t / 4), nm);
  endfunction

  // Expiry of a period-8 ramp started at b: tick 8 lands on b+32.
  function automatic void push_expire8(int b, int tail, string nm);
    push(b + 32, 3'd4, 1'b1, 16'd8, nm);
    evt_q.push_back(b + 32);
    for (int t = 33; t < 33 + tail; t++) push(b + t, 3'd5, 1'b1, 16'd8, nm);
  endfunction

  // Monitor / scoreboard
  always @(negedge sysclk) begin
    exp_t e;
    bit   exp_evt;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      n_vec++; n_err++;
      $display("FAIL %s: cycle %0d was never sampled (now %0d)", e.name, e.cyc, cyc);
    end
    while (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      n_vec++;
      if (wdog_period_status !== e.st || wdog_timeout !== e.to || wdog_elapsed !== e.el) begin
        n_err++;
        $display("FAIL %s @cyc %0d: got status=%0d timeout=%0b elapsed=%0d, expected status=%0d timeout=%0b elapsed=%0d",
                 e.name, cyc, wdog_period_status, wdog_timeout, wdog_elapsed, e.st, e.to, e.el);
      end
    end
    exp_evt = (evt_q.size() > 0 && evt_q[0] == cyc);
    if (exp_evt) void'(evt_q.pop_front());
    if (exp_evt || wdog_timeout_evt !== 1'b0) begin
      n_vec++;
      if (wdog_timeout_evt !== exp_evt) begin
        n_err++;
        $display("FAIL timeout_evt @cyc %0d: got %0b, expected %0b", cyc, wdog_timeout_evt, exp_evt);
      end
    end
    if (done) begin
      if (q.size() != 0 || evt_q.size() != 0) begin
        n_vec++; n_err++;
        $display("FAIL drain: %0d status records and %0d evt records left unchecked, expected 0",
                 q.size(), evt_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench still running at %0t, expected to have finished", $time);
    $fatal(1);
  end

  task automatic strobe_we(input logic [15:0] v);
    wdog_period_in = v;
    wdog_period_we = 1'b1;
    @(negedge sysclk);
    wdog_period_we = 1'b0;
  endtask

  initial begin
    int n, b, m, c, x, w, v, base;
    reset          = 1'b0;
    wdog_period_in = 16'd0;
    wdog_period_we = 1'b0;
    wdog_refresh   = 1'b0;
    wdog_clear     = 1'b0;

    // Reset state
    for (int i = 1; i <= 3; i++) push(i, 3'd0, 1'b0, 16'd0, "reset_state");
    repeat (3) @(negedge sysclk);
    reset = 1'b1;
    @(negedge sysclk);

    // Period 8, no refresh: phases 1..4, expiry on tick 8, status 5 a cycle later
    n = cyc; b = n + 1;
    push_ramp(b, 32, 3'd0, "p8_phases");
    push_expire8(b, 3, "p8_expire");
    strobe_we(16'd8);
    repeat (35) @(negedge sysclk);

    // Refresh while expired is ignored
    m = cyc;
    push(m + 1, 3'd5, 1'b1, 16'd8, "refresh_in_expired");
    push(m + 2, 3'd5, 1'b1, 16'd8, "refresh_in_expired");
    wdog_refresh = 1'b1;
    @(negedge sysclk);
    wdog_refresh = 1'b0;
    @(negedge sysclk);

    // Clear: timeout drops, elapsed 0, status 1 one cycle later, then runs to expiry again
    c = cyc + 1;
    push_ramp(c, 32, 3'd5, "clear_restart");
    push_expire8(c, 1, "clear_reexpire");
    wdog_clear = 1'b1;
    @(negedge sysclk);
    wdog_clear = 1'b0;
    repeat (33) @(negedge sysclk);

    // Clear and refresh together while expired: clear takes effect
    x = cyc;
    push_ramp(x + 1, 11, 3'd5, "clear_plus_refresh");
    wdog_clear   = 1'b1;
    wdog_refresh = 1'b1;
    @(negedge sysclk);
    wdog_clear   = 1'b0;
    wdog_refresh = 1'b0;
    repeat (10) @(negedge sysclk);

    // Write 0 while running (elapsed 2): elapsed 0 at once, status 0 the cycle after
    w = cyc;
    push(w + 1, 3'd2, 1'b0, 16'd0, "write0_running");
    push(w + 2, 3'd0, 1'b0, 16'd0, "write0_disable");
    push(w + 3, 3'd0, 1'b0, 16'd0, "write0_disable");
    strobe_we(16'd0);
    repeat (2) @(negedge sysclk);

    // Period 1 expires 4 sysclk after the write takes effect
    v = cyc;
    push(v + 1, 3'd0, 1'b0, 16'd0, "p1_start");
    for (int t = 2; t <= 4; t++) push(v + t, 3'd1, 1'b0, 16'd0, "p1_wait");
    push(v + 5, 3'd1, 1'b1, 16'd1, "p1_expire");
    evt_q.push_back(v + 5);
    push(v + 6, 3'd5, 1'b1, 16'd1, "p1_status");
    strobe_we(16'd1);
    repeat (5) @(negedge sysclk);

    // Back to idle, then period 8 with a refresh landing on the expiring tick
    w = cyc;
    push(w + 2, 3'd0, 1'b0, 16'd0, "idle_again");
    strobe_we(16'd0);
    @(negedge sysclk);
    n = cyc; b = n + 1;
    push_ramp(b, 32, 3'd0, "p8_before_kick");
    strobe_we(16'd8);
    repeat (31) @(negedge sysclk);
    push_ramp(b + 32, 20, 3'd4, "refresh_on_expiry");
    wdog_refresh = 1'b1;
    @(negedge sysclk);
    wdog_refresh = 1'b0;

    // Refresh every 5 ticks for 100 ticks: elapsed peaks at 4, status at 3, no timeout
    base = b + 32;
    for (int k = 0; k < 20; k++) begin
      repeat (19) @(negedge sysclk);
      push_ramp(base + 20, 20, 3'd3, "refresh_every5");
      wdog_refresh = 1'b1;
      @(negedge sysclk);
      wdog_refresh = 1'b0;
      base = base + 20;
    end
    repeat (19) @(negedge sysclk);

    // Async reset mid-count (elapsed 5), then nothing runs until a new write
    w = cyc;
    push(w + 2, 3'd0, 1'b0, 16'd0, "idle_before_rst");
    strobe_we(16'd0);
    @(negedge sysclk);
    n = cyc; b = n + 1;
    push_ramp(b, 22, 3'd0, "p8_before_rst");
    strobe_we(16'd8);
    repeat (21) @(negedge sysclk);
    for (int t = 22; t <= 63; t++) push(b + t, 3'd0, 1'b0, 16'd0, "async_reset");
    @(posedge sysclk);
    #1 reset = 1'b0;
    @(negedge sysclk);
    @(negedge sysclk);
    reset = 1'b1;
    repeat (5) @(negedge sysclk);
    wdog_refresh = 1'b1;
    wdog_clear   = 1'b1;
    @(negedge sysclk);
    wdog_refresh = 1'b0;
    wdog_clear   = 1'b0;
    repeat (34) @(negedge sysclk);
    done = 1'b1;
  end

endmodule
